// File: rtl/dmem_lsu_if.sv
// Request/response bus between the MEM stage (master) and the data memory LSU (slave).
// Valid/ready on both directions, single outstanding response slot on the slave side.
interface dmem_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_lsu.sv
// RV32I data memory with integrated load/store unit: funct3 lane decode, fault
// detection and sign/zero extension in front of a synchronous single-port RAM.
module dmem_lsu #(
   parameter int    DEPTH_WORDS = 256,
   parameter string INIT_FILE   = "./dmem.mem",
   localparam int   ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic       clk,
   input  logic       rst_n,
   dmem_lsu_if.slave  bus
);

   logic [31:0]       mem [DEPTH_WORDS];
   logic [31:0]       ram_q;

   logic [1:0]        off;
   logic [ADDR_W-1:0] idx;
   logic              oor, bad_f3, misal, req_err;
   logic [3:0]        be;
   logic [31:0]       wdata_rep;
   logic              accept, wr_en, rd_en;

   logic              resp_valid_q, resp_err_q, rd_load_q;
   logic [1:0]        rd_off_q;
   logic [2:0]        rd_f3_q;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [31:0]       rdata;

   always_comb begin
      off       = bus.req_addr[1:0];
      idx       = bus.req_addr[ADDR_W+1:2];
      oor       = (bus.req_addr >> (ADDR_W + 2)) != 32'd0;
      bad_f3    = 1'b0;
      misal     = 1'b0;
      be        = 4'b0000;
      wdata_rep = bus.req_wdata;
      if (bus.req_we) bad_f3 = (bus.req_funct3 > 3'd2);
      else            bad_f3 = (bus.req_funct3 == 3'd3) || (bus.req_funct3 > 3'd5);
      case (bus.req_funct3[1:0])
         2'd0: begin
            be        = 4'b0001 << off;
            wdata_rep = {4{bus.req_wdata[7:0]}};
         end
         2'd1: begin
            be        = 4'b0011 << off;
            wdata_rep = {2{bus.req_wdata[15:0]}};
            misal     = off[0];
         end
         default: begin
            be        = 4'b1111;
            misal     = (off != 2'd0);
         end
      endcase
      req_err = oor | bad_f3 | misal;
   end

   assign bus.req_ready = !resp_valid_q | bus.resp_ready;
   assign accept        = bus.req_valid & bus.req_ready;
   assign wr_en         = accept &  bus.req_we & !req_err;
   assign rd_en         = accept & !bus.req_we & !req_err;

   // RAM has no reset; a write at edge N is visible to a read at edge N+1.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
         end
      end
      if (rd_en) ram_q <= mem[idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         rd_load_q    <= 1'b0;
         rd_off_q     <= 2'd0;
         rd_f3_q      <= 3'd0;
      end else if (accept) begin
         resp_valid_q <= 1'b1;
         resp_err_q   <= req_err;
         rd_load_q    <= !bus.req_we & !req_err;
         rd_off_q     <= off;
         rd_f3_q      <= bus.req_funct3;
      end else if (bus.resp_ready) begin
         resp_valid_q <= 1'b0;
      end
   end

   // rd_load_q gates the mux so stores, faults and reset all read back as zero.
   always_comb begin
      byte_sel = ram_q[{rd_off_q, 3'b000} +: 8];
      half_sel = rd_off_q[1] ? ram_q[31:16] : ram_q[15:0];
      rdata    = 32'd0;
      if (rd_load_q) begin
         case (rd_f3_q)
            3'd0:    rdata = {{24{byte_sel[7]}}, byte_sel};
            3'd1:    rdata = {{16{half_sel[15]}}, half_sel};
            3'd2:    rdata = ram_q;
            3'd4:    rdata = {24'd0, byte_sel};
            3'd5:    rdata = {16'd0, half_sel};
            default: rdata = 32'd0;
         endcase
      end
   end

   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = rdata;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a driver pushes hand-computed responses into a
// scoreboard queue at accept; an independent monitor pops and compares on handshake.
module tb_dmem_lsu;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dmem_lsu_if bus ();

   dmem_lsu #(.DEPTH_WORDS(256), .INIT_FILE("")) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_acc = 0;

   localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5;
   localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Monitor: a response is consumed on any falling edge where valid & ready are both high.
   always @(negedge clk) begin
      if (rst_n && bus.resp_valid && bus.resp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got rdata %h err %b expected no response",
                     bus.resp_rdata, bus.resp_err);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, "_rdata"}, bus.resp_rdata, e.rdata);
            check({e.name, "_err"}, {31'd0, bus.resp_err}, {31'd0, e.err});
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic issue(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
      int   n = 0;
      exp_t e;
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      @(negedge clk);
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         checks++;
         errors++;
         $display("FAIL %s_accept: got req_ready 0 expected 1 within 20 cycles", name);
         @(posedge clk);
      end else begin
         @(posedge clk);
         e.name  = name;
         e.rdata = exp_rdata;
         e.err   = exp_err;
         exp_q.push_back(e);
      end
      #1;
      last_acc = cyc;
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_pending", exp_q.size(), 0);
   endtask

   initial begin
      int acc1;
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;
      bus.resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      check("rst_resp_err",   {31'd0, bus.resp_err},   32'd0);
      check("rst_resp_rdata", bus.resp_rdata, 32'd0);
      check("rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: store then load back-to-back, one response per cycle
      issue("sw_10",   1'b1, SW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
      acc1 = last_acc;
      issue("lw_10_a", 1'b0, LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
      check("b2b_accept_gap", last_acc - acc1, 1);

      // 2: byte store with sign/zero extended byte loads
      issue("sb_13",   1'b1, SB,  32'h13, 32'hFFFFFF80, 32'h0, 1'b0);
      issue("lb_13",   1'b0, LB,  32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
      issue("lbu_13",  1'b0, LBU, 32'h13, 32'h0, 32'h00000080, 1'b0);
      issue("lw_10_b", 1'b0, LW,  32'h10, 32'h0, 32'h80ADBEEF, 1'b0);

      // 3: upper halfword store, misaligned halfword load, halfword extension
      issue("sh_12",   1'b1, SH,  32'h12, 32'hAAAA1234, 32'h0, 1'b0);
      issue("lh_11",   1'b0, LH,  32'h11, 32'h0, 32'h0, 1'b1);
      issue("lw_10_c", 1'b0, LW,  32'h10, 32'h0, 32'h1234BEEF, 1'b0);
      issue("lh_12",   1'b0, LH,  32'h12, 32'h0, 32'h00001234, 1'b0);
      issue("lh_10",   1'b0, LH,  32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
      issue("lhu_10",  1'b0, LHU, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
      issue("lb_10",   1'b0, LB,  32'h10, 32'h0, 32'hFFFFFFEF, 1'b0);

      // 4: out-of-range, illegal funct3, misaligned word
      issue("sw_0",    1'b1, SW,   32'h0,   32'h11223344, 32'h0, 1'b0);
      issue("sw_400",  1'b1, SW,   32'h400, 32'h99999999, 32'h0, 1'b1);
      issue("lw_0",    1'b0, LW,   32'h0,   32'h0, 32'h11223344, 1'b0);
      issue("ld_f3_3", 1'b0, 3'd3, 32'h10,  32'h0, 32'h0, 1'b1);
      issue("st_f3_3", 1'b1, 3'd3, 32'h0,   32'h55555555, 32'h0, 1'b1);
      issue("lw_0_b",  1'b0, LW,   32'h0,   32'h0, 32'h11223344, 1'b0);
      issue("sw_11",   1'b1, SW,   32'h11,  32'h77777777, 32'h0, 1'b1);
      issue("lw_10_d", 1'b0, LW,   32'h10,  32'h0, 32'h1234BEEF, 1'b0);
      drain();

      // 5: response stall holds the slot and blocks a pending store
      bus.resp_ready = 1'b0;
      issue("lw_stall", 1'b0, LW, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = SW;
      bus.req_addr   = 32'h10;
      bus.req_wdata  = 32'hCAFEF00D;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_req_ready",  {31'd0, bus.req_ready},  32'd0);
         check("stall_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
         check("stall_resp_rdata", bus.resp_rdata, 32'h1234BEEF);
      end
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      issue("lw_after_stall", 1'b0, LW, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);
      issue("sw_cafe",        1'b1, SW, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0);
      issue("lw_cafe",        1'b0, LW, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0);
      drain();

      // 6: asynchronous reset drops a pending response, RAM survives
      bus.resp_ready = 1'b0;
      issue("lw_pre_rst", 1'b0, LW, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0);
      #2;
      check("pre_rst_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("async_rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      check("async_rst_resp_rdata", bus.resp_rdata, 32'd0);
      check("async_rst_resp_err",   {31'd0, bus.resp_err},   32'd0);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      issue("lw_post_rst", 1'b0, LW, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0);
      issue("lw_0_post",   1'b0, LW, 32'h0,  32'h0, 32'h11223344, 1'b0);
      drain();

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got simulation still running expected finish");
      $fatal(1, "timeout");
   end
endmodule
